// File: rtl/stream_tx_gen_pkg.sv
// Shared definitions for the valid/ready stream transmitter and its receiver-side peers.
package stream_tx_gen_pkg;

  // Default widths: data, beats per packet, gap cycles, packets per burst.
  localparam int DW_DEF = 16;
  localparam int LW_DEF = 8;
  localparam int GW_DEF = 8;
  localparam int PW_DEF = 8;

  // Transmitter FSM encoding, kept as plain constants so older blocks can share it.
  typedef logic [1:0] tx_state_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

endpackage

// File: rtl/stream_tx_gen_beat_counter.sv
// Loadable down-counter with zero and one flags; shared by the beat, gap and
// packet bookkeeping of the stream transmitter.
module tx_beat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         one
);

  logic [W-1:0] cnt_r;

  // Load wins over decrement; decrement saturates at zero so a stray dec cannot wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && !zero) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {W{1'b0}});
  assign one  = (cnt_r == W'(1));

endmodule

// File: rtl/stream_tx_gen.sv
// Valid/ready burst transmitter: sends cfg_pkts packets of cfg_len incrementing
// beats separated by cfg_gap idle cycles. All outputs come straight from flops,
// so tx_ready never reaches an output combinationally.
module stream_tx_gen
  import stream_tx_gen_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF,
  parameter int GW = GW_DEF,
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [LW-1:0] cfg_len,
  input  logic [GW-1:0] cfg_gap,
  input  logic [PW-1:0] cfg_pkts,
  input  logic [DW-1:0] cfg_seed,
  output logic [DW-1:0] tx_data,
  output logic          tx_valid,
  output logic          tx_last,
  input  logic          tx_ready,
  output logic          busy,
  output logic          done
);

  tx_state_t     state_r,  state_nxt_s;
  logic [DW-1:0] data_r,   data_nxt_s;
  logic          valid_r,  valid_nxt_s;
  logic          last_r,   last_nxt_s;
  logic          busy_r,   busy_nxt_s;
  logic          done_r,   done_nxt_s;
  logic [LW-1:0] len_r,    len_nxt_s;
  logic [GW-1:0] gap_r,    gap_nxt_s;

  logic          xfer_s;
  logic          beat_load_s, beat_dec_s, beat_zero_s, beat_one_s;
  logic [LW-1:0] beat_val_s;
  logic          gap_load_s,  gap_dec_s,  gap_zero_s,  gap_one_s;
  logic          pkt_load_s,  pkt_dec_s,  pkt_zero_s,  pkt_one_s;

  assign xfer_s = valid_r & tx_ready;

  // Beats still to send after the one on the bus; zero means the current beat is last.
  tx_beat_counter #(.W(LW)) u_beat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (beat_load_s),
    .load_val (beat_val_s),
    .dec      (beat_dec_s),
    .zero     (beat_zero_s),
    .one      (beat_one_s)
  );

  // Idle cycles left in the current inter-packet gap.
  tx_beat_counter #(.W(GW)) u_gap_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load_s),
    .load_val (gap_r),
    .dec      (gap_dec_s),
    .zero     (gap_zero_s),
    .one      (gap_one_s)
  );

  // Packets left in the burst, including the one being sent.
  tx_beat_counter #(.W(PW)) u_pkt_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pkt_load_s),
    .load_val (cfg_pkts),
    .dec      (pkt_dec_s),
    .zero     (pkt_zero_s),
    .one      (pkt_one_s)
  );

  // Next-state and next-output decode; everything holds unless a branch says otherwise,
  // which keeps data/last/valid stable while the receiver stalls.
  always_comb begin
    state_nxt_s = state_r;
    data_nxt_s  = data_r;
    valid_nxt_s = valid_r;
    last_nxt_s  = last_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    len_nxt_s   = len_r;
    gap_nxt_s   = gap_r;
    beat_load_s = 1'b0;
    beat_val_s  = {LW{1'b0}};
    beat_dec_s  = 1'b0;
    gap_load_s  = 1'b0;
    gap_dec_s   = 1'b0;
    pkt_load_s  = 1'b0;
    pkt_dec_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if ((cfg_len != {LW{1'b0}}) && (cfg_pkts != {PW{1'b0}})) begin
            len_nxt_s   = cfg_len;
            gap_nxt_s   = cfg_gap;
            data_nxt_s  = cfg_seed;
            valid_nxt_s = 1'b1;
            last_nxt_s  = (cfg_len == LW'(1));
            busy_nxt_s  = 1'b1;
            beat_load_s = 1'b1;
            beat_val_s  = cfg_len - LW'(1);
            pkt_load_s  = 1'b1;
            state_nxt_s = ST_SEND;
          end else begin
            // Empty burst: no beats, just the completion pulse.
            state_nxt_s = ST_FIN;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (xfer_s) begin
          data_nxt_s = data_r + DW'(1);
          if (beat_zero_s) begin
            if (pkt_one_s || pkt_zero_s) begin
              valid_nxt_s = 1'b0;
              last_nxt_s  = 1'b0;
              state_nxt_s = ST_FIN;
            end else begin
              pkt_dec_s = 1'b1;
              if (gap_r == {GW{1'b0}}) begin
                // Back-to-back: next packet's first beat follows immediately.
                beat_load_s = 1'b1;
                beat_val_s  = len_r - LW'(1);
                last_nxt_s  = (len_r == LW'(1));
              end else begin
                gap_load_s  = 1'b1;
                valid_nxt_s = 1'b0;
                last_nxt_s  = 1'b0;
                state_nxt_s = ST_GAP;
              end
            end
          end else begin
            beat_dec_s = 1'b1;
            last_nxt_s = beat_one_s;
          end
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_GAP: begin
        // Gap counter was loaded with the gap length, so leaving on "one" yields exactly gap idle cycles.
        if (gap_one_s || gap_zero_s) begin
          valid_nxt_s = 1'b1;
          last_nxt_s  = (len_r == LW'(1));
          beat_load_s = 1'b1;
          beat_val_s  = len_r - LW'(1);
          state_nxt_s = ST_SEND;
        end else begin
          gap_dec_s = 1'b1;
        end
      end
      ST_FIN: begin
        done_nxt_s  = 1'b1;
        busy_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        valid_nxt_s = 1'b0;
        last_nxt_s  = 1'b0;
        busy_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops valid at once and suppresses done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      data_r  <= {DW{1'b0}};
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      len_r   <= {LW{1'b0}};
      gap_r   <= {GW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      data_r  <= data_nxt_s;
      valid_r <= valid_nxt_s;
      last_r  <= last_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      len_r   <= len_nxt_s;
      gap_r   <= gap_nxt_s;
    end
  end

  assign tx_data  = data_r;
  assign tx_valid = valid_r;
  assign tx_last  = last_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_stream_tx_gen.sv
// Directed self-checking bench for stream_tx_gen.
module tb_stream_tx_gen;

  localparam int DW = 16;
  localparam int LW = 8;
  localparam int GW = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] cfg_len = 8'd0;
  logic [GW-1:0] cfg_gap = 8'd0;
  logic [PW-1:0] cfg_pkts = 8'd0;
  logic [DW-1:0] cfg_seed = 16'd0;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_last;
  logic          tx_ready = 1'b0;
  logic          busy;
  logic          done;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  stream_tx_gen #(.DW(DW), .LW(LW), .GW(GW), .PW(PW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cfg_len  (cfg_len),
    .cfg_gap  (cfg_gap),
    .cfg_pkts (cfg_pkts),
    .cfg_seed (cfg_seed),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge with the given configuration.
  task automatic launch(input logic [LW-1:0] len, input logic [GW-1:0] gap,
                        input logic [PW-1:0] pkts, input logic [DW-1:0] seed);
    cfg_len  = len;
    cfg_gap  = gap;
    cfg_pkts = pkts;
    cfg_seed = seed;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tx_ready = 1'b0;
    step();
    step();
    if ({tx_valid, tx_last, busy, done} !== 4'b0000) begin
      $display("FAIL reset_ctrl: got valid/last/busy/done=%b expected 0000", {tx_valid, tx_last, busy, done});
      miss_cnt++;
    end
    vec_cnt++;
    if (tx_data !== 16'h0000) begin
      $display("FAIL reset_data: got %h expected 0000", tx_data);
      miss_cnt++;
    end
    vec_cnt++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_packet();
    tx_ready = 1'b1;
    launch(8'd4, 8'd0, 8'd1, 16'h0010);
    for (int i = 0; i < 4; i++) begin
      if ({tx_valid, busy} !== 2'b11 || tx_data !== 16'h0010 + 16'(i) || tx_last !== (i == 3)) begin
        $display("FAIL single_beat[%0d]: got v=%b b=%b d=%h l=%b expected v=1 b=1 d=%h l=%b",
                 i, tx_valid, busy, tx_data, tx_last, 16'h0010 + 16'(i), (i == 3));
        miss_cnt++;
      end
      vec_cnt++;
      step();
    end
    if ({tx_valid, busy, done} !== 3'b010) begin
      $display("FAIL single_fin: got v/b/d=%b expected 010", {tx_valid, busy, done});
      miss_cnt++;
    end
    vec_cnt++;
    step();
    if ({tx_valid, busy, done} !== 3'b001) begin
      $display("FAIL single_done: got v/b/d=%b expected 001", {tx_valid, busy, done});
      miss_cnt++;
    end
    vec_cnt++;
    step();
    if (done !== 1'b0) begin
      $display("FAIL single_done_pulse: got %b expected 0", done);
      miss_cnt++;
    end
    vec_cnt++;
  endtask

  task automatic test_backpressure();
    logic rdy_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int   beat = 0;
    tx_ready = 1'b1;
    launch(8'd4, 8'd0, 8'd1, 16'h0010);
    for (int i = 0; i < 7; i++) begin
      tx_ready = rdy_pat[i];
      if (tx_valid !== 1'b1 || tx_data !== 16'h0010 + 16'(beat) || tx_last !== (beat == 3)) begin
        $display("FAIL bp_cycle[%0d]: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                 i, tx_valid, tx_data, tx_last, 16'h0010 + 16'(beat), (beat == 3));
        miss_cnt++;
      end
      vec_cnt++;
      step();
      if (rdy_pat[i]) beat++;
    end
    tx_ready = 1'b1;
    if (tx_valid !== 1'b0) begin
      $display("FAIL bp_end_valid: got %b expected 0", tx_valid);
      miss_cnt++;
    end
    vec_cnt++;
    step();
    if (done !== 1'b1) begin
      $display("FAIL bp_done: got %b expected 1", done);
      miss_cnt++;
    end
    vec_cnt++;
    step();
  endtask

  task automatic test_gap_wrap();
    logic        ev [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] ed [12] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0001,
                             16'h0000, 16'h0000, 16'h0002, 16'h0003, 16'h0000, 16'h0000};
    logic        el [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tx_ready = 1'b1;
    launch(8'd2, 8'd2, 8'd3, 16'hFFFE);
    for (int i = 0; i < 12; i++) begin
      if (tx_valid !== ev[i] || tx_last !== el[i] || (ev[i] && tx_data !== ed[i])) begin
        $display("FAIL gap_cycle[%0d]: got v=%b d=%h l=%b expected v=%b d=%h l=%b",
                 i, tx_valid, tx_data, tx_last, ev[i], ed[i], el[i]);
        miss_cnt++;
      end
      vec_cnt++;
      if (busy !== (i < 11) || done !== (i == 11)) begin
        $display("FAIL gap_status[%0d]: got busy=%b done=%b expected busy=%b done=%b",
                 i, busy, done, (i < 11), (i == 11));
        miss_cnt++;
      end
      vec_cnt++;
      step();
    end
  endtask

  task automatic test_back_to_back();
    tx_ready = 1'b1;
    launch(8'd3, 8'd0, 8'd2, 16'h1234);
    for (int i = 0; i < 6; i++) begin
      // A start mid-burst with a different config must change nothing.
      if (i == 1) begin
        cfg_len  = 8'd1;
        cfg_pkts = 8'd1;
        cfg_seed = 16'hAAAA;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (tx_valid !== 1'b1 || tx_data !== 16'h1234 + 16'(i) || tx_last !== (i == 2 || i == 5)) begin
        $display("FAIL b2b_beat[%0d]: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                 i, tx_valid, tx_data, tx_last, 16'h1234 + 16'(i), (i == 2 || i == 5));
        miss_cnt++;
      end
      vec_cnt++;
      step();
    end
    start = 1'b0;
    if (tx_valid !== 1'b0) begin
      $display("FAIL b2b_end_valid: got %b expected 0", tx_valid);
      miss_cnt++;
    end
    vec_cnt++;
    step();
    if (done !== 1'b1) begin
      $display("FAIL b2b_done: got %b expected 1", done);
      miss_cnt++;
    end
    vec_cnt++;
    step();
  endtask

  task automatic test_zero_len();
    tx_ready = 1'b1;
    launch(8'd0, 8'd0, 8'd1, 16'h4444);
    if ({tx_valid, busy, done} !== 3'b000) begin
      $display("FAIL zero_fin: got v/b/d=%b expected 000", {tx_valid, busy, done});
      miss_cnt++;
    end
    vec_cnt++;
    // Start during the FIN cycle must be ignored.
    cfg_len  = 8'd1;
    cfg_pkts = 8'd1;
    cfg_seed = 16'h5555;
    start    = 1'b1;
    step();
    start    = 1'b0;
    if ({tx_valid, busy, done} !== 3'b001) begin
      $display("FAIL zero_done: got v/b/d=%b expected 001", {tx_valid, busy, done});
      miss_cnt++;
    end
    vec_cnt++;
    step();
    if ({tx_valid, busy, done} !== 3'b000) begin
      $display("FAIL zero_after: got v/b/d=%b expected 000", {tx_valid, busy, done});
      miss_cnt++;
    end
    vec_cnt++;
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b0;
    launch(8'd4, 8'd0, 8'd1, 16'h0200);
    step();
    if (tx_valid !== 1'b1 || tx_data !== 16'h0200) begin
      $display("FAIL rmid_hold: got v=%b d=%h expected v=1 d=0200", tx_valid, tx_data);
      miss_cnt++;
    end
    vec_cnt++;
    rst_n = 1'b0;
    step();
    if ({tx_valid, busy, done} !== 3'b000) begin
      $display("FAIL rmid_reset: got v/b/d=%b expected 000", {tx_valid, busy, done});
      miss_cnt++;
    end
    vec_cnt++;
    rst_n = 1'b1;
    step();
    if (done !== 1'b0) begin
      $display("FAIL rmid_no_done: got %b expected 0", done);
      miss_cnt++;
    end
    vec_cnt++;
    tx_ready = 1'b1;
    launch(8'd2, 8'd0, 8'd1, 16'h0300);
    for (int i = 0; i < 2; i++) begin
      if (tx_valid !== 1'b1 || tx_data !== 16'h0300 + 16'(i) || tx_last !== (i == 1)) begin
        $display("FAIL rmid_fresh[%0d]: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                 i, tx_valid, tx_data, tx_last, 16'h0300 + 16'(i), (i == 1));
        miss_cnt++;
      end
      vec_cnt++;
      step();
    end
    step();
    if ({tx_valid, done} !== 2'b01) begin
      $display("FAIL rmid_fresh_done: got v/d=%b expected 01", {tx_valid, done});
      miss_cnt++;
    end
    vec_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_backpressure();
    test_gap_wrap();
    test_back_to_back();
    test_zero_len();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
